// File: rtl/hue_fade_sequencer.sv
// Hue-wheel colour source: walks six HSV segments at a fixed step rate and
// hands double-buffered R/G/B duty values to the PWM stage on period start.
module hue_fade_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES  = 1666,
  parameter int DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pwm_period_start,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          duty_valid,
  output logic [2:0]    segment
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] MAX       = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] LVL_LAST  = DW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    SEG0 = 3'd0,
    SEG1 = 3'd1,
    SEG2 = 3'd2,
    SEG3 = 3'd3,
    SEG4 = 3'd4,
    SEG5 = 3'd5
  } seg_e;

  seg_e          seg_q, seg_d;
  logic [DW-1:0] level_q, level_d;
  logic [SW-1:0] step_q, step_d;
  logic          tick;
  logic [DW-1:0] up, dn;
  logic [DW-1:0] stage_r, stage_g, stage_b;

  always_comb begin
    seg_d   = seg_q;
    level_d = level_q;
    step_d  = step_q;
    tick    = enable && (step_q == STEP_LAST);
    if (enable) begin
      step_d = tick ? '0 : step_q + 1'b1;
    end
    if (tick) begin
      if (level_q == LVL_LAST) begin
        level_d = '0;
        case (seg_q)
          SEG0:    seg_d = SEG1;
          SEG1:    seg_d = SEG2;
          SEG2:    seg_d = SEG3;
          SEG3:    seg_d = SEG4;
          SEG4:    seg_d = SEG5;
          default: seg_d = SEG0;
        endcase
      end else begin
        level_d = level_q + 1'b1;
      end
    end
  end

  // level never reaches MAX, so dn stays in 1..MAX
  assign up = level_q;
  assign dn = MAX - level_q;

  always_comb begin
    stage_r = '0;
    stage_g = '0;
    stage_b = '0;
    case (seg_q)
      SEG0:    begin stage_r = MAX; stage_g = up;  end
      SEG1:    begin stage_r = dn;  stage_g = MAX; end
      SEG2:    begin stage_g = MAX; stage_b = up;  end
      SEG3:    begin stage_g = dn;  stage_b = MAX; end
      SEG4:    begin stage_r = up;  stage_b = MAX; end
      default: begin stage_r = MAX; stage_b = dn;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= SEG0;
      level_q    <= '0;
      step_q     <= '0;
      duty_r     <= MAX;
      duty_g     <= '0;
      duty_b     <= '0;
      duty_valid <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      level_q    <= level_d;
      step_q     <= step_d;
      duty_valid <= pwm_period_start;
      // staged values come from pre-edge state, so a coincident tick lands next period
      if (pwm_period_start) begin
        duty_r <= stage_r;
        duty_g <= stage_g;
        duty_b <= stage_b;
      end
    end
  end

  assign segment = seg_q;

endmodule

// File: tb/tb_hue_fade_sequencer.sv
// Directed bench for hue_fade_sequencer with PWM_INTERVAL=4, STEP_CYCLES=3.
module tb_hue_fade_sequencer;

  localparam int PI = 4;
  localparam int SC = 3;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          pwm_period_start = 1'b0;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic          duty_valid;
  logic [2:0]    segment;

  int checks = 0;
  int errors = 0;

  hue_fade_sequencer #(.PWM_INTERVAL(PI), .STEP_CYCLES(SC)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .pwm_period_start (pwm_period_start),
    .duty_r           (duty_r),
    .duty_g           (duty_g),
    .duty_b           (duty_b),
    .duty_valid       (duty_valid),
    .segment          (segment)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, "_r"}, 32'(duty_r), r);
    chk({tag, "_g"}, 32'(duty_g), g);
    chk({tag, "_b"}, 32'(duty_b), b);
  endtask

  // Colour for a given number of ticks since reset, from the hue-wheel table.
  function automatic int wheel(input int total, input int ch);
    int s, lv, hi, lo;
    int rgb[3];
    s  = (total / PI) % 6;
    lv = total % PI;
    hi = lv;
    lo = PI - lv;
    case (s)
      0: rgb = '{PI, hi, 0};
      1: rgb = '{lo, PI, 0};
      2: rgb = '{0, PI, hi};
      3: rgb = '{0, lo, PI};
      4: rgb = '{hi, 0, PI};
      default: rgb = '{PI, 0, lo};
    endcase
    return rgb[ch];
  endfunction

  initial begin
    bit found;

    // Reset and idle with no period starts: duty must not move
    rst = 1'b1; step(); step();
    chk_rgb("reset", 4, 0, 0);
    chk("reset_valid", 32'(duty_valid), 0);
    chk("reset_seg", 32'(segment), 0);
    rst = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_rgb("idle", 4, 0, 0);
      chk("idle_valid", 32'(duty_valid), 0);
    end

    // Ramp and full wheel with a transfer every cycle
    rst = 1'b1; enable = 1'b0; step();
    rst = 1'b0; enable = 1'b1; pwm_period_start = 1'b1;
    for (int n = 1; n <= 73; n++) begin
      step();
      chk_rgb("wheel", wheel((n - 1) / SC, 0), wheel((n - 1) / SC, 1), wheel((n - 1) / SC, 2));
      chk("wheel_seg", 32'(segment), ((n / SC) / PI) % 6);
      chk("wheel_valid", 32'(duty_valid), 1);
      chk("wheel_max", 32'(duty_r <= PI && duty_g <= PI && duty_b <= PI), 1);
      if (n == 4)  chk_rgb("ramp_g1", 4, 1, 0);
      if (n == 10) chk_rgb("ramp_g3", 4, 3, 0);
      if (n == 12) chk("ramp_seg1", 32'(segment), 1);
      if (n == 13) chk_rgb("ramp_s1", 4, 4, 0);
      if (n == 22) chk_rgb("ramp_r1", 1, 4, 0);
      if (n == 72) chk_rgb("wheel_s5_end", 4, 0, 1);
      if (n == 73) chk_rgb("wheel_wrap", 4, 0, 0);
    end

    // Double-buffer: pulse every 10 clocks; pulse at n=30 coincides with a tick
    rst = 1'b1; pwm_period_start = 1'b0; step();
    rst = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      pwm_period_start = (n % 10 == 0);
      step();
      chk("db_valid", 32'(duty_valid), (n % 10 == 0) ? 1 : 0);
      if (n < 10)       chk_rgb("db_hold0", 4, 0, 0);
      else if (n < 20)  chk_rgb("db_load10", 4, 3, 0);
      else if (n < 30)  chk_rgb("db_load20", 2, 4, 0);
      else              chk_rgb("db_load30_pretick", 0, 4, 1);
    end

    // Freeze mid-S2 (level 2, step count 1) with periodic transfers
    enable = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      pwm_period_start = (i % 5 == 1);
      step();
      chk_rgb("freeze", 0, 4, 2);
      chk("freeze_valid", 32'(duty_valid), (i % 5 == 1) ? 1 : 0);
      chk("freeze_seg", 32'(segment), 2);
    end
    enable = 1'b1; pwm_period_start = 1'b1;
    step(); chk_rgb("resume_a", 0, 4, 2);
    step(); chk_rgb("resume_tick", 0, 4, 2);
    step(); chk_rgb("resume_after", 0, 4, 3);

    // Reset in the middle of S4
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (segment == 3'd4) found = 1'b1;
    end
    chk("reach_s4", 32'(found), 1);
    step();
    rst = 1'b1; step();
    chk_rgb("midrst", 4, 0, 0);
    chk("midrst_valid", 32'(duty_valid), 0);
    chk("midrst_seg", 32'(segment), 0);
    rst = 1'b0;
    step(); chk_rgb("restart1", 4, 0, 0);
    chk("restart_valid", 32'(duty_valid), 1);
    step(); step(); step();
    chk_rgb("restart4", 4, 1, 0);
    chk("restart_seg", 32'(segment), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
